// File: rtl/mem_arbiter.sv
// Two-port (I fetch / D load-store) arbiter for a single-port synchronous-read memory.
// Define MEM_ARB_RR_EN for round-robin conflict policy; default is D-priority with an I starvation guard.
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, I_RESP, D_RESP} resp_state_e;

    resp_state_e state_q, state_d;
    logic        conflict;
    logic        i_wins;

    assign conflict = i_req & d_req;

`ifdef MEM_ARB_RR_EN
    // Pointer set means I owns the next conflict; it flips to whichever port lost.
    logic rr_ptr_q, rr_ptr_d;

    assign i_wins = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (conflict) begin
            rr_ptr_d = d_gnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    localparam int            SW        = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    assign i_wins = (stall_cnt_q == STALL_MAX);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_gnt || !i_req) begin
            stall_cnt_d = '0;
        end else if (d_gnt && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

    // Grants are gated by reset so they drop the instant reset asserts.
    assign i_gnt = reset & i_req & (~d_req | i_wins);
    assign d_gnt = reset & d_req & ~(i_req & i_wins);

    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;

    always_comb begin
        state_d = IDLE;
        if (i_gnt) begin
            state_d = I_RESP;
        end else if (d_gnt && !d_we) begin
            state_d = D_RESP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign i_rvalid = (state_q == I_RESP);
    assign d_rvalid = (state_q == D_RESP);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_mem_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_STALL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_STALL(MAX_STALL)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory with a backdoor preload port.
    bit   [31:0] mem [0:4095];
    logic        bd_en;
    logic [11:0] bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_en) mem[bd_idx] <= bd_data;
        else if (mem_en && mem_we) mem[mem_addr[13:2]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[13:2]];
    end

    // Reference model state.
    bit   [31:0] model_mem [0:4095];
    int          i_losses;
    bit          rr_i_turn;
    int          pend_kind;   // 0 none, 1 I read, 2 D read
    logic [31:0] pend_data;
    logic        obs_i_gnt, obs_d_gnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        i_losses  = 0;
        rr_i_turn = 1'b0;
        pend_kind = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".i_gnt"},    {31'd0, i_gnt},    32'd0);
        check({tag, ".d_gnt"},    {31'd0, d_gnt},    32'd0);
        check({tag, ".mem_en"},   {31'd0, mem_en},   32'd0);
        check({tag, ".mem_we"},   {31'd0, mem_we},   32'd0);
        check({tag, ".i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
        check({tag, ".d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_quiet("rst_now");
        repeat (2) @(posedge clk);
        #1;
        check_quiet("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic poke(input logic [11:0] idx, input logic [31:0] val);
        bd_en   = 1'b1;
        bd_idx  = idx;
        bd_data = val;
        model_mem[idx] = val;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, return just after the edge.
    task automatic eval();
        bit          i_wins, exp_i, exp_d;
        logic [31:0] exp_addr;
        @(negedge clk);
        obs_i_gnt = i_gnt;
        obs_d_gnt = d_gnt;
        check("i_rvalid", {31'd0, i_rvalid}, {31'd0, pend_kind == 1});
        check("d_rvalid", {31'd0, d_rvalid}, {31'd0, pend_kind == 2});
        if (pend_kind == 1) check("i_rdata", i_rdata, pend_data);
        if (pend_kind == 2) check("d_rdata", d_rdata, pend_data);
`ifdef MEM_ARB_RR_EN
        i_wins = rr_i_turn;
`else
        i_wins = (i_losses >= MAX_STALL);
`endif
        exp_i    = i_req && (!d_req || i_wins);
        exp_d    = d_req && !exp_i;
        exp_addr = exp_d ? d_addr : i_addr;
        check("i_gnt",    {31'd0, i_gnt},  {31'd0, exp_i});
        check("d_gnt",    {31'd0, d_gnt},  {31'd0, exp_d});
        check("mem_en",   {31'd0, mem_en}, {31'd0, exp_i || exp_d});
        check("mem_we",   {31'd0, mem_we}, {31'd0, exp_d && d_we});
        check("mem_addr", mem_addr, exp_addr);
        if (exp_d && d_we) check("mem_wdata", mem_wdata, d_wdata);

        pend_kind = 0;
        if (exp_i) begin
            pend_kind = 1;
            pend_data = model_mem[i_addr[13:2]];
        end else if (exp_d) begin
            if (d_we) model_mem[d_addr[13:2]] = d_wdata;
            else begin
                pend_kind = 2;
                pend_data = model_mem[d_addr[13:2]];
            end
        end
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) rr_i_turn = exp_d;
`else
        if (exp_i || !i_req) i_losses = 0;
        else if (exp_d) i_losses = (i_losses + 1 > MAX_STALL) ? MAX_STALL : i_losses + 1;
`endif
        @(posedge clk);
        #1;
    endtask

    // Both ports requesting continuously: D grant expected on cycle k per the active policy.
    function automatic bit exp_pattern_d(input int k);
`ifdef MEM_ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k % (MAX_STALL + 1)) != MAX_STALL;
`endif
    endfunction

    task automatic contention(input int cycles, input string tag);
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
        for (int k = 0; k < cycles; k++) begin
            eval();
            check(tag, {31'd0, obs_d_gnt}, {31'd0, exp_pattern_d(k)});
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h100;
        return 32'h2000 + ($urandom_range(0, 15) << 2);
    endfunction

    task automatic rand_inputs();
        if (i_req && !obs_i_gnt) begin
            if ($urandom_range(0, 9) == 0) i_req = 1'b0;
        end else begin
            i_req  = $urandom_range(0, 1) == 1;
            i_addr = rand_addr();
        end
        if (d_req && !obs_d_gnt) begin
            if ($urandom_range(0, 9) == 0) d_req = 1'b0;
        end else begin
            d_req   = $urandom_range(0, 2) != 0;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = rand_addr();
            d_wdata = $urandom;
        end
    endtask

    initial begin
        rst_n = 1'b0; bd_en = 1'b0; bd_idx = '0; bd_data = '0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0;
        obs_i_gnt = 1'b0; obs_d_gnt = 1'b0;
        model_reset();
        poke(12'h040, 32'h0050_0093);

        // Reset with both requesting, then D must win the first cycle.
        do_reset();
        eval();
        check("first_after_reset_d", {31'd0, obs_d_gnt}, 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        eval();

        // Solo instruction fetch.
        i_req = 1'b1; i_addr = 32'h100;
        repeat (3) eval();
        i_req = 1'b0;
        eval();

        // Store then load to the same address.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        eval();
        d_we = 1'b0;
        eval();
        d_req = 1'b0;
        eval();
        check("store_load_data", model_mem[12'h800], 32'hDEAD_BEEF);

        // Continuous contention from a clean reset.
        do_reset();
        contention(10, "pattern");
        eval();

        // Reset while a D read response is in flight.
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        repeat (2) eval();
        check("pre_reset_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        do_reset();
        repeat (2) eval();
        contention(MAX_STALL + 2, "pattern_after_reset");
        eval();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            eval();
        end
        i_req = 1'b0; d_req = 1'b0;
        eval();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
